// File: rtl/mem_responder.sv
// mem_responder: memory side of the 16-bit processor bus.
// - Holds a DEPTH-word program/data RAM with a registered read port.
// - Preloads the RAM from a streaming loader while the processor is held in
//   reset (LOAD).
// - Then serves processor reads and writes (RUN).
// - A memory-mapped console FIFO drains bytes to an external sink.
module mem_responder #(
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [15:0] CON_ADDR   = 16'hFF00,
  parameter logic [15:0] STAT_ADDR  = 16'hFF01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic        we,
  input  logic [15:0] toMem,
  output logic [15:0] fromMem,
  output logic        cpu_rst,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_data,
  input  logic        load_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned FAW = $clog2(FIFO_DEPTH);

  localparam logic [15:0]   RAM_LIMIT = 16'(DEPTH);
  localparam logic [AW-1:0] PTR_LAST  = AW'(DEPTH - 1);
  localparam logic [FAW:0]  FIFO_FULL = (FAW + 1)'(FIFO_DEPTH);

  typedef enum logic {
    S_LOAD = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [AW-1:0]  ptr_q, ptr_d;
  logic [15:0]    from_mem_q, from_mem_d;
  logic [FAW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FAW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FAW:0]   count_q, count_d;
  logic           overflow_q, overflow_d;

  logic [15:0] mem    [DEPTH];
  logic [7:0]  fifo_q [FIFO_DEPTH];

  logic          is_run;
  logic          in_ram;
  logic [AW-1:0] ram_raddr;
  logic          load_hs;
  logic          load_done;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [15:0]   ram_wdata;
  logic          fifo_empty;
  logic          fifo_full;
  logic          push_req;
  logic          push_ok;
  logic          pop;

  assign is_run    = (state_q == S_RUN);
  assign in_ram    = (addr < RAM_LIMIT);
  assign ram_raddr = addr[AW-1:0];
  assign load_hs   = load_valid & load_ready;
  // The load ends on an explicit last word, or when the final RAM word is filled.
  assign load_done = load_hs & (load_last | (ptr_q == PTR_LAST));

  // State register: LOAD after reset, RUN until the next reset.
  // NOTE: every clocked register is updated with <= so that all flops sample
  // the values from before the edge, no matter in which order the blocks run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_LOAD;
    else      state_q <= state_d;
  end

  // Next state: leave LOAD on the final loader handshake. RUN is terminal.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_LOAD:  if (load_done) state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      default: state_d = S_LOAD;
    endcase
  end

  // Outputs decoded from the state flop. They therefore switch on the same
  // edge that enters RUN.
  // NOTE: every output is given a default value before the case statement.
  // This means no path leaves it unassigned, so no latch is inferred.
  always_comb begin
    cpu_rst    = 1'b1;
    load_ready = 1'b1;
    unique case (state_q)
      S_LOAD: begin
        cpu_rst    = 1'b1;
        load_ready = 1'b1;
      end
      S_RUN: begin
        cpu_rst    = 1'b0;
        load_ready = 1'b0;
      end
      default: ;
    endcase
  end

  // RAM write port source.
  // - In LOAD, the loader writes at the load pointer.
  // - In RUN, the processor writes inside the RAM window.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = ptr_q;
    ram_wdata = load_data;
    if (!is_run) begin
      ram_we = load_hs;
    end else if (we && in_ram) begin
      ram_we    = 1'b1;
      ram_waddr = ram_raddr;
      ram_wdata = toMem;
    end
  end

  // Load pointer advances once per accepted loader word.
  always_comb begin
    ptr_d = ptr_q;
    if (load_hs) ptr_d = ptr_q + AW'(1);
  end

  // Read data mux.
  // - It is sampled into fromMem, so the latency is one cycle.
  // - It sees the pre-write RAM contents, so a read during a write to the
  //   same address returns the old data.
  always_comb begin
    from_mem_d = '0;
    if (is_run) begin
      if (in_ram) begin
        from_mem_d = mem[ram_raddr];
      end else if (addr == STAT_ADDR) begin
        from_mem_d = {13'b0, overflow_q, fifo_full, fifo_empty};
      end
    end
  end

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FIFO_FULL);
  assign push_req   = is_run & we & (addr == CON_ADDR);
  assign pop        = ~fifo_empty & out_ready;
  // A pop in the same cycle frees a slot, so a push to a full FIFO can still land.
  assign push_ok    = push_req & (~fifo_full | pop);

  // Console FIFO bookkeeping.
  // - Pointers wrap naturally because FIFO_DEPTH is a power of two.
  // - A dropped push sets the sticky overflow flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + FAW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + FAW'(1);
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + (FAW + 1)'(1);
      2'b01:   count_d = count_q - (FAW + 1)'(1);
      default: count_d = count_q;
    endcase
    if (push_req && !push_ok) overflow_d = 1'b1;
  end

  // Control and FIFO bookkeeping registers. All of them return to idle on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q      <= '0;
      from_mem_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      from_mem_q <= from_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // RAM storage.
  // NOTE: the storage arrays have no reset. RAM contents survive a processor
  // reset, and FIFO slots are only read behind a non-empty count. Leaving the
  // arrays unreset also lets them map onto memory macros.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
  end

  // FIFO slot storage. Only the low byte of the bus write data is kept.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_q[wr_ptr_q] <= toMem[7:0];
  end

  assign fromMem   = from_mem_q;
  assign out_valid = ~fifo_empty;
  assign out_data  = fifo_empty ? 8'h00 : fifo_q[rd_ptr_q];

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the 16-bit processor bus: the processor drives addr/we/toMem, and this block returns fromMem.
- Holds program/data RAM.
- Preloads that RAM from a streaming loader port while holding the processor in reset.
- Exposes a memory-mapped console output FIFO that drains to an external byte sink.

Parameters:
DEPTH, 256, number of 16-bit RAM words; valid RAM addresses 0..DEPTH-1 (power of two, ≤ 0xFF00)
FIFO_DEPTH, 4, console FIFO entries (power of two)
CON_ADDR, 16'hFF00, console data register (write-only)
STAT_ADDR, 16'hFF01, console status register (read-only)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
addr  input  16  bus address from processor
we  input  1  bus write enable from processor
toMem  input  16  bus write data from processor
fromMem  output  16  registered bus read data to processor
cpu_rst  output  1  active-high reset to processor, asserted while loading
load_valid  input  1  loader word valid
load_ready  output  1  responder accepts loader word
load_data  input  16  loader word
load_last  input  1  qualifies final loader word
out_valid  output  1  console byte available
out_ready  input  1  sink accepts console byte
out_data  output  8  console byte (FIFO head)

Behaviour:
- Reset (rst low, async) values:
  - state = LOAD, load pointer = 0, fromMem = 0, cpu_rst = 1, load_ready = 1.
  - FIFO empty, out_valid = 0, out_data = 0, overflow flag = 0.
  - RAM contents are not cleared.
- Two states, LOAD and RUN.
- LOAD:
  - Handshake = load_valid & load_ready at a rising edge: mem[ptr] <= load_data, ptr <= ptr+1.
  - Handshake with load_last=1, or handshake at ptr = DEPTH-1, moves to RUN on the same edge.
  - load_valid low: no change.
  - Bus inputs are ignored; fromMem holds 0.
- RUN:
  - load_ready = 0 and cpu_rst = 0 (both registered, so they change on the edge that enters RUN).
  - RUN is left only by reset.
- Bus read (RUN), 1-cycle latency: fromMem at edge N+1 reflects addr sampled at edge N.
  - addr < DEPTH: mem[addr].
  - addr == STAT_ADDR: {13'b0, overflow, full, empty}.
  - Any other address: 16'h0000.
- Bus write (RUN, we=1), on the sampled edge:
  - addr < DEPTH: mem[addr] <= toMem.
  - Read-during-write to the same address returns old data.
  - addr == CON_ADDR: push toMem[7:0] into the FIFO.
  - Other addresses: write ignored; fromMem = 0 for that cycle.
- FIFO:
  - out_valid = !empty; out_data = head entry.
  - Pop on out_valid & out_ready.
  - Push when full is dropped and sets sticky overflow; only reset clears overflow.
  - Push and pop on the same edge while full: both occur, occupancy unchanged, no overflow.
  - Push and pop on the same edge while empty: push only; out_valid rises next cycle.
  - Pointers wrap modulo FIFO_DEPTH; occupancy counter width is log2(FIFO_DEPTH)+1.
- Reset mid-LOAD or mid-RUN:
  - All control and FIFO state returns to reset values immediately.
  - A subsequent load restarts at address 0.
- Width rules:
  - RAM index = addr[log2(DEPTH)-1:0], used only when addr < DEPTH.
  - Load pointer is log2(DEPTH) bits.

Test Plan:
- Load 3 words 0xC105, 0x1002, 0x7777 with load_last on the third → mem[0..2] hold them; cpu_rst falls on the edge after the third handshake; load_ready = 0 thereafter.
- RUN: addr=0x0001, we=0 → fromMem = 0x1002 one cycle later. Then addr=0x0001, we=1, toMem=0xBEEF → same-cycle read returns 0x1002, next read returns 0xBEEF.
- Write 0x0041, 0x0042 to 0xFF00 with out_ready=0 → out_valid=1, out_data=0x41. Raise out_ready for 2 cycles → bytes 0x41 then 0x42 drained, out_valid=0, STAT read = 0x0001.
- Write 5 bytes to 0xFF00 with out_ready=0 (FIFO_DEPTH=4) → 5th dropped; STAT reads 0x0006 (overflow=1, full=1); draining yields only the first 4 bytes.
- Assert rst low after 2 of 4 load words → cpu_rst=1, load_ready=1 immediately. Reload 1 word with load_last → stored at address 0, RUN entered.
- Read addr=0x8000 and write it → fromMem = 0x0000; RAM and FIFO unchanged.
